// File: rtl/vp_pixel_serializer.sv
// Double-buffered 16-pixel word serializer: one pixel per pixel_tick, registered output.
// Latency: word in next slot moves to active one edge after accept. Backpressure: in_ready = !nxt_full.
module vp_pixel_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  foreground,
    input  logic [3:0]  background,
    input  logic [15:0] bitmap,
    input  logic        enable,
    input  logic        pixel_tick,
    input  logic        line_start,
    output logic [3:0]  pixel,
    output logic        pixel_valid,
    output logic        underrun
);

    logic [3:0]  act_fg;
    logic [3:0]  act_bg;
    logic [15:0] act_bm;
    logic        act_en;
    logic        act_full;
    logic [3:0]  idx;

    logic [3:0]  nxt_fg;
    logic [3:0]  nxt_bg;
    logic [15:0] nxt_bm;
    logic        nxt_en;
    logic        nxt_full;

    logic        accept;
    logic        last_px;
    logic        load_act;
    logic [3:0]  cur_px;

    assign in_ready = ~nxt_full;

    // line_start swallows any word offered in the same cycle
    assign accept   = in_valid & ~nxt_full & ~line_start;
    assign last_px  = (idx == 4'd15);
    assign load_act = ~line_start & nxt_full & (~act_full | (pixel_tick & last_px));
    assign cur_px   = act_en ? (act_bm[4'd15 - idx] ? act_fg : act_bg) : 4'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_full    <= 1'b0;
            nxt_full    <= 1'b0;
            idx         <= 4'd0;
            pixel       <= 4'h0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
        end else if (line_start) begin
            act_full    <= 1'b0;
            nxt_full    <= 1'b0;
            idx         <= 4'd0;
            pixel       <= 4'h0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            pixel_valid <= pixel_tick & act_full;
            underrun    <= pixel_tick & ~act_full;
            if (pixel_tick) begin
                pixel <= act_full ? cur_px : 4'h0;
            end

            if (load_act) begin
                act_full <= 1'b1;
            end else if (act_full && pixel_tick && last_px) begin
                act_full <= 1'b0;
            end

            if (load_act) begin
                idx <= 4'd0;
            end else if (act_full && pixel_tick) begin
                idx <= idx + 4'd1;
            end

            // accept and load are exclusive: accept needs next empty, load needs it full
            if (accept) begin
                nxt_full <= 1'b1;
            end else if (load_act) begin
                nxt_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_act) begin
            act_fg <= nxt_fg;
            act_bg <= nxt_bg;
            act_bm <= nxt_bm;
            act_en <= nxt_en;
        end
        if (accept) begin
            nxt_fg <= foreground;
            nxt_bg <= background;
            nxt_bm <= bitmap;
            nxt_en <= enable;
        end
    end

endmodule
